// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: stage-0 h/v counters with pixel request, registered sync/blank/RGB two cycles later.
// Defining VGA_TEST_PATTERN_EN replaces upstream pixel data with eight vertical colour bars.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int CNT_W     = 11,
  parameter int CW        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  input  logic [CW-1:0]    pix_r,
  input  logic [CW-1:0]    pix_g,
  input  logic [CW-1:0]    pix_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic [CW-1:0]    vga_r,
  output logic [CW-1:0]    vga_g,
  output logic [CW-1:0]    vga_b,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic             SYNC_ACT = (SYNC_POL != 0);

  logic             en_q;
  logic [CNT_W-1:0] h_cnt_p0, v_cnt_p0;
  logic             vis_p0, hs_p0, vs_p0, fs_p0;
  logic             vis_p1, hs_p1, vs_p1, fs_p1;
  logic [3*CW-1:0]  rgb_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= en;
  end

  // Stage 0: counters. Clearing on !en as well keeps them at 0 for every cycle en_q is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (!en || !en_q) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == H_LAST) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + CNT_W'(1);
    end else begin
      h_cnt_p0 <= h_cnt_p0 + CNT_W'(1);
    end
  end

  always_comb begin
    vis_p0 = en_q && (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
    hs_p0  = en_q && (h_cnt_p0 >= HS_FIRST) && (h_cnt_p0 <= HS_LAST);
    vs_p0  = en_q && (v_cnt_p0 >= VS_FIRST) && (v_cnt_p0 <= VS_LAST);
    fs_p0  = en_q && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
  end

  assign pix_req = vis_p0;
  assign pix_x   = h_cnt_p0;
  assign pix_y   = v_cnt_p0;

  // Stage 1: flags delayed to line up with the upstream pixel data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      vis_p1 <= vis_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      fs_p1  <= fs_p0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;

  logic [CNT_W-1:0] x_p1;
  logic             unused_pix;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black is the inverted 3-bit index.
  function automatic logic [3*CW-1:0] bar_rgb(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] idx;
    idx = x / CNT_W'(BAR_W);
    return {{CW{~idx[1]}}, {CW{~idx[2]}}, {CW{~idx[0]}}};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_p1 <= '0;
    else        x_p1 <= h_cnt_p0;
  end

  assign unused_pix = ^{pix_r, pix_g, pix_b};
  assign rgb_src    = bar_rgb(x_p1);
`else
  assign rgb_src = {pix_r, pix_g, pix_b};
`endif

  // Stage 2: DAC-facing output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~SYNC_ACT;
      vga_vs      <= ~SYNC_ACT;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= hs_p1 ? SYNC_ACT : ~SYNC_ACT;
      vga_vs      <= vs_p1 ? SYNC_ACT : ~SYNC_ACT;
      vga_blank_n <= vis_p1;
      {vga_r, vga_g, vga_b} <= vis_p1 ? rgb_src : '0;
      frame_start <= fs_p1;
    end
  end

endmodule
